// File: rtl/mem_defs.sv
// Shared CPU-bus address map and OAM DMA state encoding.
package mem_defs;

  localparam logic [15:0] PPU_REG_BASE  = 16'h2000;
  localparam logic [15:0] OAM_ADDR_ADDR = 16'h2003;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;

  typedef logic [2:0] dma_state_t;

  localparam dma_state_t IDLE    = 3'd0;
  localparam dma_state_t ALIGN   = 3'd1;
  localparam dma_state_t RD_ADDR = 3'd2;
  localparam dma_state_t RD_WAIT = 3'd3;
  localparam dma_state_t WR      = 3'd4;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA initiator: passes CPU traffic through when idle, and on a $4014 write
// stalls the CPU and copies page P00..PFF into sprite RAM via $2004.
module oam_dma_ctrl #(
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [15:0] DMA_REG_ADDR  = mem_defs::DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = mem_defs::OAM_DATA_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_data_out,
  input  logic        core_write_en,
  input  logic        core_read_en,
  output logic [7:0]  core_data_in,
  output logic        core_stall,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_write_en,
  output logic        bus_read_en,
  input  logic [7:0]  bus_data_in,
  output logic        dma_busy
);
  import mem_defs::*;

  // RD_WAIT runs READ_LATENCY cycles, so the counter starts one below that.
  localparam logic [1:0] WAIT_INIT = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

  dma_state_t state, state_next;
  logic [7:0] page, page_next;
  logic [7:0] idx, idx_next;
  logic [7:0] data_latch, latch_next;
  logic [1:0] wait_cnt, wait_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      page       <= 8'h00;
      idx        <= 8'h00;
      data_latch <= 8'h00;
      wait_cnt   <= 2'd0;
    end else begin
      state      <= state_next;
      page       <= page_next;
      idx        <= idx_next;
      data_latch <= latch_next;
      wait_cnt   <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    page_next  = page;
    idx_next   = idx;
    latch_next = data_latch;
    wait_next  = wait_cnt;
    case (state)
      IDLE: begin
        if (core_write_en && (core_addr == DMA_REG_ADDR)) begin
          page_next  = core_data_out;
          idx_next   = 8'h00;
          state_next = ALIGN;
        end
      end
      ALIGN: state_next = RD_ADDR;
      RD_ADDR: begin
        if (READ_LATENCY == 0) begin
          latch_next = bus_data_in;
          state_next = WR;
        end else begin
          wait_next  = WAIT_INIT;
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_cnt == 2'd0) begin
          latch_next = bus_data_in;
          state_next = WR;
        end else begin
          wait_next = wait_cnt - 2'd1;
        end
      end
      WR: begin
        // idx never carries into page, so page FF ends at $FFFF.
        if (idx == 8'hFF) begin
          state_next = IDLE;
        end else begin
          idx_next   = idx + 8'd1;
          state_next = RD_ADDR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_addr     = 16'h0000;
    bus_data_out = 8'h00;
    bus_write_en = 1'b0;
    bus_read_en  = 1'b0;
    core_data_in = 8'h00;
    case (state)
      IDLE: begin
        bus_addr     = core_addr;
        bus_data_out = core_data_out;
        bus_write_en = core_write_en;
        bus_read_en  = core_read_en;
        core_data_in = bus_data_in;
      end
      RD_ADDR: begin
        bus_addr    = {page, idx};
        bus_read_en = 1'b1;
      end
      RD_WAIT: bus_addr = {page, idx};
      WR: begin
        bus_addr     = OAM_DATA_ADDR;
        bus_data_out = data_latch;
        bus_write_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Both derive from the async-reset state register, so they drop immediately on rst.
  assign dma_busy   = (state != IDLE);
  assign core_stall = (state != IDLE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: two DUTs (read latency 1 and 2) in front of a CPU memory /
// sprite-RAM model, with a queue of expected sprite-RAM writes.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        rst           [2];
  logic [15:0] core_addr     [2];
  logic [7:0]  core_data_out [2];
  logic        core_write_en [2];
  logic        core_read_en  [2];
  logic [7:0]  core_data_in  [2];
  logic        core_stall    [2];
  logic [15:0] bus_addr      [2];
  logic [7:0]  bus_data_out  [2];
  logic        bus_write_en  [2];
  logic        bus_read_en   [2];
  logic [7:0]  bus_data_in   [2];
  logic        dma_busy      [2];

  logic [7:0]  mem     [2][65536];
  logic [7:0]  oam     [2][256];
  logic [7:0]  exp_oam [2][256];
  logic [7:0]  oam_ptr [2];
  logic [7:0]  pipe1   [2];
  logic [7:0]  pipe2   [2];
  logic [15:0] last_rd [2];
  int          zero_hits [2];
  logic [16:0] sb [$];

  int total = 0;
  int bad   = 0;

  oam_dma_ctrl #(.READ_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]), .core_addr(core_addr[0]), .core_data_out(core_data_out[0]),
    .core_write_en(core_write_en[0]), .core_read_en(core_read_en[0]),
    .core_data_in(core_data_in[0]), .core_stall(core_stall[0]), .bus_addr(bus_addr[0]),
    .bus_data_out(bus_data_out[0]), .bus_write_en(bus_write_en[0]),
    .bus_read_en(bus_read_en[0]), .bus_data_in(bus_data_in[0]), .dma_busy(dma_busy[0])
  );

  oam_dma_ctrl #(.READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst[1]), .core_addr(core_addr[1]), .core_data_out(core_data_out[1]),
    .core_write_en(core_write_en[1]), .core_read_en(core_read_en[1]),
    .core_data_in(core_data_in[1]), .core_stall(core_stall[1]), .bus_addr(bus_addr[1]),
    .bus_data_out(bus_data_out[1]), .bus_write_en(bus_write_en[1]),
    .bus_read_en(bus_read_en[1]), .bus_data_in(bus_data_in[1]), .dma_busy(dma_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory controller model: $2003 sets the sprite pointer, $2004 writes and increments it.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bus_write_en[k]) begin
        if (bus_addr[k] == 16'h2003) oam_ptr[k] <= bus_data_out[k];
        else if (bus_addr[k] == 16'h2004) begin
          oam[k][oam_ptr[k]] <= bus_data_out[k];
          oam_ptr[k]         <= oam_ptr[k] + 8'd1;
        end else mem[k][bus_addr[k]] <= bus_data_out[k];
      end
      pipe1[k] <= mem[k][bus_addr[k]];
      pipe2[k] <= pipe1[k];
    end
  end

  always_comb begin
    bus_data_in[0] = pipe1[0];
    bus_data_in[1] = pipe2[1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dma_busy[k]) begin
        if (bus_read_en[k]) begin
          last_rd[k] <= bus_addr[k];
          if (bus_addr[k] == 16'h0000) zero_hits[k] <= zero_hits[k] + 1;
        end
        if (bus_write_en[k] && bus_addr[k] == 16'h2004) begin
          if (sb.size() == 0) chk("sb_unexpected_write", 32'(sb.size()), 32'd1);
          else chk("sb_oam_write", {15'd0, k[0], oam_ptr[k], bus_data_out[k]},
                   {15'd0, sb.pop_front()});
        end
      end
    end
  end

  function automatic logic [7:0] pat(input logic [7:0] p, input logic [7:0] i);
    return (p == 8'h02) ? (i ^ 8'hA5) : ((i + p * 8'd7) ^ 8'h3C);
  endfunction

  task automatic cw(input int k, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    core_addr[k]     = a;
    core_data_out[k] = d;
    core_write_en[k] = 1'b1;
    @(negedge clk);
    core_write_en[k] = 1'b0;
  endtask

  task automatic fill_page(input int k, input logic [7:0] p);
    for (int j = 0; j < 256; j++) cw(k, {p, 8'(j)}, pat(p, 8'(j)));
  endtask

  task automatic push_exp(input int k, input logic [7:0] p, input logic [7:0] start,
                          input int n);
    logic [7:0] dest;
    logic [7:0] d;
    for (int j = 0; j < n; j++) begin
      dest = start + 8'(j);
      d    = pat(p, 8'(j));
      sb.push_back({k[0], dest, d});
      exp_oam[k][dest] = d;
    end
  endtask

  // Leaves a $4014 write (different page) asserted into the stall; it must be ignored.
  task automatic trigger(input int k, input logic [7:0] p);
    @(negedge clk);
    core_addr[k]     = 16'h4014;
    core_data_out[k] = p;
    core_write_en[k] = 1'b1;
    #1;
    chk("trigger_forwarded", {15'd0, bus_write_en[k], bus_addr[k]}, {15'd0, 1'b1, 16'h4014});
    @(negedge clk);
    core_data_out[k] = 8'h99;
    #1;
    chk("align_state", {20'd0, core_stall[k], dma_busy[k], bus_read_en[k], bus_write_en[k],
        core_data_in[k]}, {20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
  endtask

  task automatic wait_done(input int k, input int exp_stall, input string tag);
    int n;
    n = 0;
    while (core_stall[k] && n < 3000) begin
      n++;
      if (n == 4) core_write_en[k] = 1'b0;
      @(negedge clk);
    end
    core_write_en[k] = 1'b0;
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_idle_after"}, {31'd0, dma_busy[k]}, 32'd0);
    chk({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_oam(input int k, input string tag);
    for (int j = 0; j < 256; j++) chk(tag, {24'd0, oam[k][j]}, {24'd0, exp_oam[k][j]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int z0;
    for (int k = 0; k < 2; k++) begin
      rst[k]           = 1'b1;
      core_addr[k]     = 16'h0000;
      core_data_out[k] = 8'h00;
      core_write_en[k] = 1'b0;
      core_read_en[k]  = 1'b0;
      zero_hits[k]     = 0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk("reset_state", {28'd0, dma_busy[k], core_stall[k], bus_write_en[k], bus_read_en[k]},
          32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Idle pass-through write and read.
    @(negedge clk);
    core_addr[0] = 16'h0300; core_data_out[0] = 8'h5A; core_write_en[0] = 1'b1;
    #1;
    chk("idle_write_mirror", {bus_addr[0], bus_data_out[0], bus_write_en[0], bus_read_en[0],
        core_stall[0]}, {16'h0300, 8'h5A, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    core_write_en[0] = 1'b0; core_read_en[0] = 1'b1;
    #1;
    chk("idle_read_mirror", {15'd0, bus_read_en[0], bus_addr[0]}, {15'd0, 1'b1, 16'h0300});
    @(negedge clk);
    chk("idle_read_data", {23'd0, core_stall[0], core_data_in[0]}, {23'd0, 1'b0, 8'h5A});
    core_addr[0] = 16'h4014;
    repeat (2) @(negedge clk);
    chk("read_4014_no_dma", {31'd0, dma_busy[0]}, 32'd0);
    core_read_en[0] = 1'b0;

    // Basic DMA from page 02 into sprite RAM at 0.
    fill_page(0, 8'h02);
    cw(0, 16'h2003, 8'h00);
    push_exp(0, 8'h02, 8'h00, 256);
    trigger(0, 8'h02);
    wait_done(0, 769, "basic");
    check_oam(0, "basic_oam");

    // Offset destination with wrap at EF -> 00.
    fill_page(0, 8'h03);
    cw(0, 16'h2003, 8'h10);
    push_exp(0, 8'h03, 8'h10, 256);
    trigger(0, 8'h03);
    wait_done(0, 769, "offset");
    check_oam(0, "offset_oam");

    // Page FF ends at $FFFF and never touches $0000.
    fill_page(0, 8'hFF);
    cw(0, 16'h2003, 8'h00);
    push_exp(0, 8'hFF, 8'h00, 256);
    z0 = zero_hits[0];
    trigger(0, 8'hFF);
    wait_done(0, 769, "page_ff");
    chk("page_ff_last_read", {16'd0, last_rd[0]}, 32'h0000_FFFF);
    chk("page_ff_zero_reads", 32'(zero_hits[0] - z0), 32'd0);
    check_oam(0, "page_ff_oam");

    // Reset when idx reaches 40.
    cw(0, 16'h2003, 8'h00);
    for (int j = 0; j < 256; j++) begin
      cw(0, 16'h2004, 8'hC0 ^ 8'(j));
      exp_oam[0][j] = 8'hC0 ^ 8'(j);
    end
    fill_page(0, 8'h04);
    cw(0, 16'h2003, 8'h00);
    push_exp(0, 8'h04, 8'h00, 64);
    trigger(0, 8'h04);
    n = 0;
    while (!(bus_read_en[0] && bus_addr[0] == 16'h0440) && n < 2000) begin
      n++;
      if (n == 3) core_write_en[0] = 1'b0;
      @(negedge clk);
    end
    core_write_en[0] = 1'b0;
    chk("reset_reached_idx40", {16'd0, bus_addr[0]}, 32'h0000_0440);
    rst[0] = 1'b1;
    #1;
    chk("reset_async_drop", {30'd0, dma_busy[0], core_stall[0]}, 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    chk("reset_sb_drained", 32'(sb.size()), 32'd0);
    check_oam(0, "reset_partial_oam");

    // Restart after reset covers the whole page again.
    cw(0, 16'h2003, 8'h80);
    push_exp(0, 8'h04, 8'h80, 256);
    trigger(0, 8'h04);
    wait_done(0, 769, "restart");
    check_oam(0, "restart_oam");

    // Latency-2 build.
    fill_page(1, 8'h02);
    cw(1, 16'h2003, 8'h00);
    push_exp(1, 8'h02, 8'h00, 256);
    trigger(1, 8'h02);
    wait_done(1, 1025, "lat2");
    check_oam(1, "lat2_oam");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Bus initiator for sprite-RAM DMA: a CPU write to $4014 captures page P.
- It then stalls the CPU and copies CPU-space bytes P00..PFF into sprite RAM through 256 writes to $2004.
- Sits between the CPU core and the memory controller's CPU port (cpu_addr/cpu_data_in/cpu_data_out/cpu_write_en/cpu_read_en).
- Passes CPU traffic through unchanged when idle and owns that port while a transfer is active.

Parameters:
- READ_LATENCY, 1: cycles from read address presented to valid bus_data_in (0..3).
- DMA_REG_ADDR, 16'h4014: trigger register address.
- OAM_DATA_ADDR, 16'h2004: sprite RAM data port address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- core_addr  in  16  CPU core address
- core_data_out  in  8  CPU core write data
- core_write_en  in  1  CPU core write strobe
- core_read_en  in  1  CPU core read strobe
- core_data_in  out  8  read data returned to the CPU core
- core_stall  out  1  high = CPU core must hold (RDY low)
- bus_addr  out  16  to memory controller cpu_addr
- bus_data_out  out  8  to memory controller cpu_data_in
- bus_write_en  out  1  to memory controller cpu_write_en
- bus_read_en  out  1  to memory controller cpu_read_en
- bus_data_in  in  8  from memory controller cpu_data_out
- dma_busy  out  1  high while state != IDLE

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All state and registered outputs clear immediately on rst=1.
- Reset values: state=IDLE, page=0, idx=0, data_latch=0, wait_cnt=0, core_stall=0, dma_busy=0, bus_write_en=0, bus_read_en=0.
- IDLE (combinational pass-through):
  - bus_addr=core_addr, bus_data_out=core_data_out, bus_write_en=core_write_en, bus_read_en=core_read_en.
  - core_data_in=bus_data_in.
  - The $4014 write itself is still forwarded to the bus.
- Trigger: in IDLE with core_write_en=1 and core_addr==DMA_REG_ADDR at a clk edge:
  - page<=core_data_out, idx<=0, state<=ALIGN.
  - core_stall=1 from the next cycle onward.
  - core_read_en on $4014 does nothing.
- DMA states: bus driven by the DMA only; core_* inputs ignored; core_data_in=0.
  - ALIGN: 1 cycle, bus idle (strobes 0) -> RD_ADDR.
  - RD_ADDR: 1 cycle.
    - bus_addr={page,idx}, bus_read_en=1.
    - If READ_LATENCY==0: data_latch<=bus_data_in, next WR. Otherwise wait_cnt<=READ_LATENCY-1, next RD_WAIT.
  - RD_WAIT: READ_LATENCY cycles.
    - bus_addr held, bus_read_en=0.
    - On the cycle wait_cnt==0: data_latch<=bus_data_in, next WR. Otherwise wait_cnt decrements.
  - WR: 1 cycle.
    - bus_addr=OAM_DATA_ADDR, bus_data_out=data_latch, bus_write_en=1.
    - If idx==8'hFF -> IDLE, else idx<=idx+1 -> RD_ADDR.
- Latency: stall lasts exactly 1 + 256*(2+READ_LATENCY) cycles; 769 at default. core_stall falls in the cycle after the final WR.
- Width rules:
  - idx is 8-bit; source address is {page,idx} and never carries into page. Page FF ends at $FFFF with no wrap to $0000.
  - Sprite RAM destination index is owned by the memory controller's auto-increment, so the transfer starts at the current $2003 value and wraps mod 256 there.
- Simultaneous events: a $4014 write from the core while busy is impossible (stalled) and is ignored if presented. A trigger and rst in the same cycle: rst wins.
- Reset mid-transfer: immediate return to IDLE; partial sprite RAM contents are left as written; stall drops asynchronously.
- No combinational path from bus_data_in to any bus_* output.

Decomposition:
- Shared package mem_defs:
  - address constants: DMA_REG_ADDR, OAM_DATA_ADDR, PPU register base $2000;
  - state encoding dma_state_t (IDLE, ALIGN, RD_ADDR, RD_WAIT, WR), 3-bit.
- No sub-module; the FSM, counters and the pass-through mux fit in one module. The test bench instantiates the memory controller behind it.

Test Plan:
- Idle pass-through: core write $0300=8'h5A, then read $0300 -> bus mirrors core, core_data_in=8'h5A, core_stall=0.
- Basic DMA: fill $0200..$02FF with i^8'hA5, write $2003=0, write $4014=8'h02 -> 256 WR cycles, sprite RAM[i]=i^8'hA5, core_stall high for exactly 769 cycles.
- Offset destination: $2003=8'h10 then DMA page $03 -> sprite RAM[(i+16)&8'hFF]=mem[$0300+i], wrap at 8'hEF->8'h00.
- Page FF: DMA page 8'hFF -> last read address $FFFF, no access to $0000, clean return to IDLE.
- Reset mid-transfer: assert rst at idx=8'h40 -> dma_busy=0 and core_stall=0 immediately; sprite RAM[0..3F] written, [40..FF] unchanged; the next $4014 write restarts from idx 0.
- READ_LATENCY=2 build: stall = 1+256*4 = 1025 cycles, data correct against a 2-cycle-latency memory model.
